// File: rtl/byte_decode_stream.sv
// Streaming ML-KEM ByteDecode_d: consumes 32*d input bytes as beats and emits
// 256 d-bit coefficients one per handshake, reducing mod 3329 when d = 12.
module byte_decode_stream #(
   parameter int IN_BYTES = 4,
   parameter int BUF_W    = 8*IN_BYTES+12
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [3:0]            d_i,
   input  logic                  abort_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   input  logic                  in_valid_i,
   input  logic [8*IN_BYTES-1:0] in_data_i,
   output logic                  in_ready_o,
   output logic                  out_valid_o,
   output logic [11:0]           out_data_o,
   output logic [7:0]            out_idx_o,
   input  logic                  out_ready_i
);

   localparam int IN_W = 8*IN_BYTES;
   localparam int FW   = $clog2(BUF_W+1);
   localparam int SH   = $clog2(IN_BYTES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q;
   logic [3:0]       d_q;
   logic [8:0]       beats_left_q;
   logic [FW-1:0]    fill_q;
   logic [BUF_W-1:0] buf_q;
   logic [7:0]       coef_cnt_q;
   logic             out_valid_q;
   logic [11:0]      out_data_q;
   logic [7:0]       out_idx_q;
   logic             err_q;

   logic             d_ok;
   logic [FW-1:0]    d_ext;
   logic             out_fire;
   logic             in_fire;
   logic             pop;
   logic             last_fire;
   logic [BUF_W-1:0] buf_shift;
   logic [BUF_W-1:0] buf_next;
   logic [FW-1:0]    fill_pop;
   logic [FW-1:0]    fill_next;
   logic [11:0]      raw;
   logic [11:0]      coef;

   assign d_ok       = (d_i != 4'd0) && (d_i <= 4'd12);
   assign d_ext      = FW'(d_q);
   assign out_fire   = out_valid_q && out_ready_i;
   assign in_ready_o = (state_q == S_RUN) && (beats_left_q != '0) &&
                       (fill_q <= FW'(BUF_W-IN_W));
   assign in_fire    = in_valid_i && in_ready_o;
   assign pop        = (state_q == S_RUN) && (fill_q >= d_ext) &&
                       (!out_valid_q || out_fire);
   assign last_fire  = out_fire && (out_idx_q == 8'd255);

   // Pop is applied first so a same-cycle beat lands at fill - d.
   always_comb begin
      buf_shift = pop ? (buf_q >> d_q) : buf_q;
      fill_pop  = pop ? (fill_q - d_ext) : fill_q;
      buf_next  = buf_shift;
      fill_next = fill_pop;
      if (in_fire) begin
         buf_next  = buf_shift | (BUF_W'(in_data_i) << fill_pop);
         fill_next = fill_pop + FW'(IN_W);
      end
   end

   assign raw  = buf_q[11:0] & ~(12'hFFF << d_q);
   assign coef = ((d_q == 4'd12) && (raw >= 12'd3329)) ? (raw - 12'd3329) : raw;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         d_q          <= '0;
         beats_left_q <= '0;
         fill_q       <= '0;
         buf_q        <= '0;
         coef_cnt_q   <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_idx_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (d_ok) begin
                     d_q          <= d_i;
                     beats_left_q <= 9'(({5'b0, d_i} << 5) >> SH);
                     fill_q       <= '0;
                     buf_q        <= '0;
                     coef_cnt_q   <= '0;
                     out_valid_q  <= 1'b0;
                     out_data_q   <= '0;
                     out_idx_q    <= '0;
                     state_q      <= S_RUN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (abort_i) begin
                  state_q      <= S_IDLE;
                  out_valid_q  <= 1'b0;
                  fill_q       <= '0;
                  buf_q        <= '0;
                  beats_left_q <= '0;
                  coef_cnt_q   <= '0;
               end else begin
                  buf_q  <= buf_next;
                  fill_q <= fill_next;
                  if (in_fire) beats_left_q <= beats_left_q - 9'd1;
                  if (pop) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= coef;
                     out_idx_q   <= coef_cnt_q;
                     coef_cnt_q  <= coef_cnt_q + 8'd1;
                  end else if (out_fire) begin
                     out_valid_q <= 1'b0;
                  end
                  if (last_fire) state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);
   assign done_o      = (state_q == S_DONE);
   assign err_o       = err_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_idx_o   = out_idx_q;

endmodule

// File: tb/tb_byte_decode_stream.sv
// Randomized bench for byte_decode_stream: a bit-stream reference model feeds a
// scoreboard queue that an independent monitor drains on each output handshake.
module tb_byte_decode_stream;

   localparam int IN_BYTES = 4;
   localparam int IN_W     = 8*IN_BYTES;
   localparam int BUF_W    = IN_W + 12;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              start_i;
   logic [3:0]        d_i;
   logic              abort_i;
   logic              busy_o;
   logic              done_o;
   logic              err_o;
   logic              in_valid_i;
   logic [IN_W-1:0]   in_data_i;
   logic              in_ready_o;
   logic              out_valid_o;
   logic [11:0]       out_data_o;
   logic [7:0]        out_idx_o;
   logic              out_ready_i;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   int exp_q[$];

   byte_decode_stream #(.IN_BYTES(IN_BYTES), .BUF_W(BUF_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .d_i(d_i),
      .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_idx_o(out_idx_o),
      .out_ready_i(out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: a handshake seen at the falling edge completes at the next rising edge.
   initial begin
      int e;
      logic        prev_stall;
      logic [11:0] held_d;
      logic [7:0]  held_i;
      prev_stall = 1'b0;
      held_d = '0;
      held_i = '0;
      forever begin
         @(negedge clk_i);
         if (rst_ni && prev_stall && out_valid_o) begin
            check("stall_data", int'(out_data_o), int'(held_d));
            check("stall_idx", int'(out_idx_o), int'(held_i));
         end
         if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("coef_idx", int'(out_idx_o), e >> 12);
               check("coef_data", int'(out_data_o), e & 12'hFFF);
            end
            hs_cnt++;
         end
         prev_stall = rst_ni && out_valid_o && !out_ready_i;
         held_d = out_data_o;
         held_i = out_idx_o;
      end
   end

   // mode: 0 random, 1 all 0xFF, 2 all 0xA5, 3 random with 01 23 45 67 first.
   // kill: 0 none, 1 abort, 2 reset once kill_at coefficients have been taken.
   task automatic run_frame(input int d, input int mode, input int in_pct,
                            input int out_pct, input int kill_at, input int kill,
                            input bit poke);
      byte unsigned bytes [384];
      int  nbeats, beats, cyc, val, pos, fill_model;
      bit  done, killed, accepted;
      nbeats = 32*d/IN_BYTES;
      for (int m = 0; m < 32*d; m++) begin
         case (mode)
            1:       bytes[m] = 8'hFF;
            2:       bytes[m] = 8'hA5;
            default: bytes[m] = 8'($urandom_range(255));
         endcase
      end
      if (mode == 3) begin
         bytes[0] = 8'h01; bytes[1] = 8'h23; bytes[2] = 8'h45; bytes[3] = 8'h67;
      end
      for (int i = 0; i < 256; i++) begin
         val = 0;
         for (int b = 0; b < d; b++) begin
            pos = i*d + b;
            val += ((bytes[pos/8] >> (pos%8)) & 1) << b;
         end
         if (d == 12 && val >= 3329) val -= 3329;
         exp_q.push_back((i << 12) | val);
      end
      hs_cnt = 0;
      start_i = 1'b1;
      d_i = 4'(d);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("start_busy", int'(busy_o), 1);
      check("start_out_valid", int'(out_valid_o), 0);
      check("start_err", int'(err_o), 0);
      beats = 0; cyc = 0; done = 0; killed = 0;
      while (!done && !killed && cyc < 5000) begin
         out_ready_i = ($urandom_range(99) >= out_pct);
         in_valid_i  = (beats < nbeats) && ($urandom_range(99) >= in_pct);
         for (int k = 0; k < IN_BYTES; k++)
            in_data_i[8*k +: 8] = (beats < nbeats) ? bytes[beats*IN_BYTES + k] : 8'h00;
         start_i = poke && (beats == 3);
         if (start_i) d_i = 4'd3;
         if (in_ready_o) begin
            fill_model = IN_W*beats - d*(hs_cnt + int'(out_valid_o));
            check("in_ready_fill_bound", int'(fill_model <= BUF_W - IN_W), 1);
            check("in_ready_beats_left", int'(beats < nbeats), 1);
         end
         if (kill != 0 && hs_cnt >= kill_at) begin
            in_valid_i = 1'b0;
            out_ready_i = 1'b0;
            start_i = 1'b0;
            killed = 1;
            if (kill == 1) begin
               abort_i = 1'b1;
               @(posedge clk_i); #1;
               abort_i = 1'b0;
               check("abort_busy", int'(busy_o), 0);
               check("abort_out_valid", int'(out_valid_o), 0);
               check("abort_in_ready", int'(in_ready_o), 0);
               for (int c = 0; c < 4; c++) begin
                  check("abort_no_done", int'(done_o), 0);
                  @(posedge clk_i); #1;
               end
            end else begin
               #2 rst_ni = 1'b0;
               #1;
               check("rst_busy", int'(busy_o), 0);
               check("rst_out_valid", int'(out_valid_o), 0);
               check("rst_out_data", int'(out_data_o), 0);
               check("rst_out_idx", int'(out_idx_o), 0);
               check("rst_in_ready", int'(in_ready_o), 0);
               check("rst_done_err", int'({done_o, err_o}), 0);
               repeat (2) @(posedge clk_i);
               #3 rst_ni = 1'b1;
               @(posedge clk_i); #1;
            end
            exp_q.delete();
         end else begin
            accepted = in_valid_i && in_ready_o;
            @(posedge clk_i); #1;
            if (accepted) beats++;
            if (done_o) done = 1;
            cyc++;
         end
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b0;
      start_i = 1'b0;
      if (!killed) begin
         check("frame_done", int'(done), 1);
         check("frame_coef_count", hs_cnt, 256);
         check("frame_beats", beats, nbeats);
         check("frame_queue_empty", exp_q.size(), 0);
         check("done_busy_high", int'(busy_o), 1);
         @(posedge clk_i); #1;
         check("post_done_busy", int'(busy_o), 0);
         check("post_done_pulse", int'(done_o), 0);
         exp_q.delete();
      end
   endtask

   task automatic illegal_start(input int d);
      start_i = 1'b1;
      d_i = 4'(d);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("illegal_err_pulse", int'(err_o), 1);
      check("illegal_busy", int'(busy_o), 0);
      @(posedge clk_i); #1;
      check("illegal_err_clear", int'(err_o), 0);
      check("illegal_busy_after", int'(busy_o), 0);
   endtask

   initial begin
      rst_ni = 1'b0;
      start_i = 1'b0; d_i = '0; abort_i = 1'b0;
      in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_busy", int'(busy_o), 0);
      check("reset_done", int'(done_o), 0);
      check("reset_err", int'(err_o), 0);
      check("reset_in_ready", int'(in_ready_o), 0);
      check("reset_out_valid", int'(out_valid_o), 0);
      check("reset_out_data", int'(out_data_o), 0);
      check("reset_out_idx", int'(out_idx_o), 0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      run_frame(12, 3, 0, 0, 0, 0, 0);
      run_frame(12, 1, 0, 30, 0, 0, 0);
      run_frame(1, 2, 0, 0, 0, 0, 0);
      run_frame(5, 0, 40, 40, 0, 0, 1);
      illegal_start(0);
      illegal_start(13);
      run_frame(7, 0, 20, 20, 10, 1, 0);
      run_frame(12, 0, 10, 10, 0, 0, 0);
      run_frame(12, 0, 0, 0, 20, 2, 0);
      for (int f = 0; f < 3; f++)
         run_frame(int'($urandom_range(12, 1)), 0, 30, 30, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
